// File: rtl/ram1_responder.sv
// Ram1 asynchronous-SRAM bus responder.
// Oversamples the active-low OE/WE strobes on clk, holds DEPTH 16-bit words,
// commits writes on the WE rising edge and drives read data after RD_LAT
// extra cycles. Sticky flags record OE/WE conflicts and out-of-range accesses.
module ram1_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  input  logic        Ram1OE,
  input  logic        Ram1WE,
  output logic        conflict,
  output logic        oor,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DRIVE,
    S_WR_ACTIVE
  } state_t;

  // Synchronizer stages.
  logic        r_oe_s1, r_oe_s2;
  logic        r_we_s1, r_we_s2;
  logic [17:0] r_addr_s1, r_addr_s2;
  logic [15:0] r_data_s1, r_data_s2;

  // Control and data path.
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_drive_en;
  logic [15:0] r_data_q;
  logic [17:0] r_addr_l;
  logic [15:0] r_data_l;
  logic [15:0] r_mem [DEPTH];

  logic        w_addr_oor;
  logic        w_wr_oor;
  logic [15:0] w_rd_word;
  logic        w_mem_we;

  // Bus is released whenever the responder is not actively driving a read.
  assign Ram1Data = r_drive_en ? r_data_q : 16'bz;

  // Any address bit above the index range makes the access out of range.
  assign w_addr_oor = (r_addr_s2 >> ADDR_W) != 18'd0;
  assign w_wr_oor   = (r_addr_l >> ADDR_W) != 18'd0;
  assign w_rd_word  = w_addr_oor ? 16'h0000 : r_mem[r_addr_s2[ADDR_W-1:0]];
  // Gating with rst drops a write whose commit edge coincides with reset.
  assign w_mem_we   = rst && (r_state == S_WR_ACTIVE) && r_we_s2 && !w_wr_oor;

  // Two-flop synchronizers for every bus input; strobes idle high in reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples its input from before the edge, giving true pipelining.
    if (!rst) begin
      r_oe_s1   <= 1'b1;
      r_oe_s2   <= 1'b1;
      r_we_s1   <= 1'b1;
      r_we_s2   <= 1'b1;
      r_addr_s1 <= '0;
      r_addr_s2 <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      r_oe_s1   <= Ram1OE;
      r_oe_s2   <= r_oe_s1;
      r_we_s1   <= Ram1WE;
      r_we_s2   <= r_we_s1;
      r_addr_s1 <= Ram1Addr;
      r_addr_s2 <= r_addr_s1;
      r_data_s1 <= Ram1Data;
      r_data_s2 <= r_data_s1;
    end
  end

  // Word storage; written on the commit edge of an in-range write.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset so it maps onto block RAM and its
    // contents survive a bus reset.
    if (w_mem_we) begin
      r_mem[r_addr_l[ADDR_W-1:0]] <= r_data_l;
    end
  end

  // Protocol FSM with registered drive enable, read data, flags and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_drive_en <= 1'b0;
      r_data_q   <= '0;
      r_addr_l   <= '0;
      r_data_l   <= '0;
      conflict   <= 1'b0;
      oor        <= 1'b0;
      wr_count   <= '0;
      rd_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_oe_s2 && !r_we_s2) begin
            conflict <= 1'b1;
          end else if (!r_oe_s2) begin
            rd_count <= rd_count + 16'd1;
            if (w_addr_oor) oor <= 1'b1;
            if (RD_LAT == 0) begin
              r_data_q   <= w_rd_word;
              r_drive_en <= 1'b1;
              r_state    <= S_RD_DRIVE;
            end else begin
              r_cnt   <= 4'(RD_LAT - 1);
              r_state <= S_RD_WAIT;
            end
          end else if (!r_we_s2) begin
            r_addr_l <= r_addr_s2;
            r_data_l <= r_data_s2;
            r_state  <= S_WR_ACTIVE;
          end
        end

        S_RD_WAIT: begin
          if (r_oe_s2) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_data_q   <= w_rd_word;
            r_drive_en <= 1'b1;
            r_state    <= S_RD_DRIVE;
            if (w_addr_oor) oor <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_RD_DRIVE: begin
          // Track address changes while OE stays low.
          r_data_q <= w_rd_word;
          if (w_addr_oor) oor <= 1'b1;
          if (r_oe_s2) begin
            r_drive_en <= 1'b0;
            r_state    <= S_IDLE;
          end else if (!r_we_s2) begin
            conflict   <= 1'b1;
            r_drive_en <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        S_WR_ACTIVE: begin
          if (!r_oe_s2) conflict <= 1'b1;
          if (!r_we_s2) begin
            r_addr_l <= r_addr_s2;
            r_data_l <= r_data_s2;
          end else begin
            if (w_wr_oor) oor <= 1'b1;
            else          wr_count <= wr_count + 16'd1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
